// File: rtl/gtv_disp.sv
// Drives a 4-digit multiplexed common-anode 7-segment display from the live count and mode.
// Count-to-display latency 11 clocks via a sequential shift-add-3 converter; no backpressure, count is resampled when idle.
module gtv_disp #(
   parameter int SCAN_DIV = 25000,
   parameter bit LZB      = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] count,
   input  logic [2:0] mode,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);

   localparam int             PW      = $clog2(SCAN_DIV);
   localparam logic [PW-1:0]  PRE_MAX = PW'(SCAN_DIV - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t      state, state_nx;
   logic [7:0]  shreg, shreg_nx;
   logic [7:0]  lat, lat_nx;
   logic [7:0]  last, last_nx;
   logic [11:0] bcd, bcd_nx, adj;
   logic [2:0]  iter, iter_nx;
   logic [3:0]  hund, hund_nx, tens, tens_nx, ones, ones_nx;

   logic [PW-1:0] presc, presc_nx;
   logic [1:0]    dig, dig_nx;
   logic [6:0]    seg_nx;
   logic          dp_nx;
   logic [3:0]    an_nx;
   logic [3:0]    dig_val;
   logic          blank;

   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'd0:    glyph = 7'b1000000;
         4'd1:    glyph = 7'b1111001;
         4'd2:    glyph = 7'b0100100;
         4'd3:    glyph = 7'b0110000;
         4'd4:    glyph = 7'b0011001;
         4'd5:    glyph = 7'b0010010;
         4'd6:    glyph = 7'b0000010;
         4'd7:    glyph = 7'b1111000;
         4'd8:    glyph = 7'b0000000;
         4'd9:    glyph = 7'b0010000;
         default: glyph = 7'b1111111;
      endcase
   endfunction

   // Double-dabble correction applied before each shift
   always_comb begin
      adj = bcd;
      for (int i = 0; i < 3; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_nx = state;
      shreg_nx = shreg;
      lat_nx   = lat;
      last_nx  = last;
      bcd_nx   = bcd;
      iter_nx  = iter;
      hund_nx  = hund;
      tens_nx  = tens;
      ones_nx  = ones;
      case (state)
         IDLE: begin
            if (count != last) begin
               shreg_nx = count;
               lat_nx   = count;
               bcd_nx   = 12'd0;
               iter_nx  = 3'd0;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            {bcd_nx, shreg_nx} = {adj[10:0], shreg, 1'b0};
            iter_nx = iter + 3'd1;
            if (iter == 3'd7) state_nx = COMMIT;
         end
         COMMIT: begin
            hund_nx  = bcd[11:8];
            tens_nx  = bcd[7:4];
            ones_nx  = bcd[3:0];
            last_nx  = lat;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      presc_nx = presc + 1'b1;
      dig_nx   = dig;
      if (presc == PRE_MAX) begin
         presc_nx = '0;
         dig_nx   = dig + 2'd1;
      end
   end

   // Digit 3 carries the mode and the only lit decimal point
   always_comb begin
      dig_val = ones;
      blank   = 1'b0;
      case (dig)
         2'd0: dig_val = ones;
         2'd1: begin
            dig_val = tens;
            blank   = LZB && (hund == 4'd0) && (tens == 4'd0);
         end
         2'd2: begin
            dig_val = hund;
            blank   = LZB && (hund == 4'd0);
         end
         default: dig_val = {1'b0, mode};
      endcase
      an_nx  = ~(4'b0001 << dig);
      dp_nx  = (dig != 2'd3);
      seg_nx = blank ? 7'b1111111 : glyph(dig_val);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         shreg <= 8'd0;
         lat   <= 8'd0;
         last  <= 8'd0;
         bcd   <= 12'd0;
         iter  <= 3'd0;
         hund  <= 4'd0;
         tens  <= 4'd0;
         ones  <= 4'd0;
         presc <= '0;
         dig   <= 2'd0;
         seg   <= 7'b1111111;
         dp    <= 1'b1;
         an    <= 4'b1111;
      end else begin
         state <= state_nx;
         shreg <= shreg_nx;
         lat   <= lat_nx;
         last  <= last_nx;
         bcd   <= bcd_nx;
         iter  <= iter_nx;
         hund  <= hund_nx;
         tens  <= tens_nx;
         ones  <= ones_nx;
         presc <= presc_nx;
         dig   <= dig_nx;
         seg   <= seg_nx;
         dp    <= dp_nx;
         an    <= an_nx;
      end
   end

endmodule

// File: tb/tb_gtv_disp.sv
// Bench for gtv_disp: two instances (blanking on/off) checked every cycle against a value-level display model.
module tb_gtv_disp;

   localparam int SD = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] count;
   logic [2:0] mode;
   logic [6:0] seg1, seg0;
   logic       dp1, dp0;
   logic [3:0] an1, an0;

   int checks = 0;
   int errors = 0;
   bit run = 1'b0;

   logic [6:0] glyph_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   gtv_disp #(.SCAN_DIV(SD), .LZB(1'b1)) u_dut_lzb1 (
      .clk(clk), .rst(rst), .count(count), .mode(mode), .seg(seg1), .dp(dp1), .an(an1));
   gtv_disp #(.SCAN_DIV(SD), .LZB(1'b0)) u_dut_lzb0 (
      .clk(clk), .rst(rst), .count(count), .mode(mode), .seg(seg0), .dp(dp0), .an(an0));

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got {an,dp,seg}=%b required %b", tag, $time, got, exp);
      end
   endtask

   // Expected {an,dp,seg} for a displayed value on digit position d
   function automatic logic [11:0] exp_out(input int v, input int d, input int md, input bit lzb);
      int h, t, o, val;
      bit blank;
      logic [3:0] a;
      h = v / 100;
      t = (v / 10) % 10;
      o = v % 10;
      blank = 1'b0;
      case (d)
         0: val = o;
         1: begin val = t; blank = lzb && h == 0 && t == 0; end
         2: begin val = h; blank = lzb && h == 0; end
         default: val = md;
      endcase
      a = 4'b1111;
      a[d] = 1'b0;
      return {a, (d == 3) ? 1'b0 : 1'b1, blank ? 7'b1111111 : glyph_tab[val]};
   endfunction

   // Reference: value is sampled when idle, becomes visible 10 edges later
   int k, busy, lat, last, disp;
   logic [11:0] exp1, exp0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         k = 0; busy = 0; lat = 0; last = 0; disp = 0;
         exp1 = 12'hfff;
         exp0 = 12'hfff;
      end else begin
         exp1 = exp_out(disp, (k / SD) % 4, int'(mode), 1'b1);
         exp0 = exp_out(disp, (k / SD) % 4, int'(mode), 1'b0);
         k++;
         if (busy == 0) begin
            if (int'(count) != last) begin
               lat  = int'(count);
               busy = 1;
            end
         end else if (busy < 9) begin
            busy++;
         end else begin
            disp = lat;
            last = lat;
            busy = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (run) begin
         check_eq("cyc_lzb1", {an1, dp1, seg1}, exp1);
         check_eq("cyc_lzb0", {an0, dp0, seg0}, exp0);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin
      rst   = 1'b1;
      count = 8'd0;
      mode  = 3'd0;
      #1 rst = 1'b0;
      tick(3);
      check_eq("rst_dark1", {an1, dp1, seg1}, 12'hfff);
      check_eq("rst_dark0", {an0, dp0, seg0}, 12'hfff);
      run = 1'b1;
      rst = 1'b1;
      tick(20);

      count = 8'd255;
      tick(40);

      count = 8'd7;
      tick(40);

      count = 8'd100;
      tick(30);
      count = 8'd0;
      tick(30);
      count = 8'd100;
      tick(4);
      count = 8'd199;
      tick(40);

      count = 8'd128;
      tick(4);
      rst = 1'b0;
      #1;
      check_eq("mid_rst1", {an1, dp1, seg1}, 12'hfff);
      check_eq("mid_rst0", {an0, dp0, seg0}, 12'hfff);
      tick(2);
      rst = 1'b1;
      tick(40);

      count = 8'd105;
      mode  = 3'd5;
      tick(40);

      for (int i = 0; i < 40; i++) begin
         count = 8'($urandom);
         mode  = 3'($urandom);
         tick($urandom_range(1, 25));
      end
      tick(40);

      run = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gtv_disp.md
# gtv_disp

Display-side consumer of the game-timer/event counter: takes the live 8-bit count and 3-bit mode and drives a 4-digit, multiplexed, common-anode 7-segment display.
- Converts binary to BCD with a sequential shift-add-3 engine, not a combinational divider.
- Scans the digits round-robin and blanks leading zeros.
- Sits between the counter block and the board display pins, on the same clock.

## Interface
Parameters:
- SCAN_DIV, 25000: clk cycles each digit stays lit; legal range 2 to 2^20.
- LZB, 1: 1 enables leading-zero blanking on the hundreds and tens digits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low; one clock, no other clock domains.
- count  input  8  unsigned value to display, synchronous to clk.
- mode  input  3  counter mode, shown on the leftmost digit, synchronous to clk.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- an  output  4  digit enables, active-low, one-hot: an[0]=ones, an[1]=tens, an[2]=hundreds, an[3]=mode.

## Operation
- Conversion FSM has three states: IDLE, SHIFT, COMMIT.
  - IDLE: if count != last, the next edge latches count into an 8-bit shift register, clears the 12-bit BCD accumulator, sets iter=0 and moves to SHIFT.
  - SHIFT: each edge first adds 3 to every BCD nibble >= 5, then shifts {bcd, shreg} left by 1 and increments iter. After the 8th shift, move to COMMIT.
  - COMMIT: one edge copies the BCD result to hund/tens/ones display registers, sets last to the latched value and returns to IDLE.
- count is ignored outside IDLE. A change during conversion is picked up by the IDLE compare once the current conversion finishes. Intermediate values may never be displayed; the final value always is.
- Scan logic:
  - The prescaler counts 0..SCAN_DIV-1. At the terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
  - seg, dp and an are registered from the digit index, the display registers and mode.
- Digit content:
  - Digit 0 shows ones and is never blanked.
  - Digit 1 shows tens, blanked when LZB=1 and hund==0 and tens==0.
  - Digit 2 shows hundreds, blanked when LZB=1 and hund==0.
  - Digit 3 shows mode as the decimal digit 0-7, with dp=0 on this digit only.
- A blanked digit has its an bit low and seg=7'b1111111.
- Glyphs (active-low, gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Hundreds never exceeds 2, since 255 is the maximum count.

## Timing
- Reset asserted:
  - FSM goes to IDLE; last=0; hund/tens/ones=0; prescaler=0; digit index=0.
  - Outputs: seg=7'b1111111, dp=1, an=4'b1111 (dark).
- First edge after reset release: an=4'b1110, seg=1000000 (shows "0").
- Conversion latency, with count changed and stable before edge E0 in IDLE:
  - E0 latches; E1..E8 shift; E9 commits.
  - The new glyph is on seg at edge E10 if the ones digit is active. Total 11 clocks.
- Reset asserted mid-conversion aborts immediately; the display returns to "0". Any nonzero count reconverts after release.
- Digit dwell time is exactly SCAN_DIV cycles. One full frame is 4*SCAN_DIV cycles. an changes on the edge after the prescaler wraps.
- mode reaches the display on the next edge while digit 3 is active; it has no conversion latency.
- count==last in IDLE means no activity and the display is unchanged.

## Test plan
- Reset and release with count=0, mode=0, SCAN_DIV=4 → an cycles 1110,1101,1011,0111 every 4 clocks. seg is 1000000 on digits 0 and 3, 1111111 on digits 1 and 2. dp=0 only while an=0111.
- count=255 → within 11 clocks the display registers read hund=2, tens=5, ones=5. Glyphs are 0100100, 0010010, 0010010.
- count=7, LZB=1 → tens and hundreds are blank and ones=1111000. Repeat with LZB=0 → tens and hundreds show 1000000.
- count 100→199 changed at the 3rd SHIFT cycle → 100 commits first, then 199 commits 10 clocks later; final digits are 1,9,9.
- count=128, rst pulsed low during SHIFT → outputs go dark immediately. After release the display shows "0", then reconverts to 1,2,8.
- count=105, mode=5 → digits read 5 . 1 0 5, and the tens digit is not blanked because hund≠0.
